capture_unit: RTL

CAPTURE_UNIT -- requirements
Module: capture_unit

---
 rtl/capture_pkg.sv | 15 +
 rtl/capture_decim.sv | 30 +++
 rtl/capture_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared defaults and types for the capture controller.
package capture_pkg;

  localparam int CAP_ENTRIES = 384;
  localparam int CAP_ADDR_W  = 9;
  localparam int CAP_DECIM_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POST    = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/capture_decim.sv
// Sample decimator: flags one of every 2^decimator strobes while enabled.
// Only instantiated when CAPTURE_DECIMATE_EN is defined.
module capture_decim
  import capture_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       wrt_smpl,
  input  logic [3:0] decimator,
  output logic       keep
);

  logic [CAP_DECIM_W-1:0] decim_cnt_reg;
  logic [CAP_DECIM_W-1:0] decim_limit;

  // 2^decimator - 1; decimator=15 gives a 32768-strobe period.
  assign decim_limit = CAP_DECIM_W'((32'd1 << decimator) - 32'd1);
  assign keep        = en && wrt_smpl && (decim_cnt_reg == decim_limit);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      decim_cnt_reg <= '0;
    end else if (en && wrt_smpl) begin
      decim_cnt_reg <= keep ? '0 : decim_cnt_reg + CAP_DECIM_W'(1);
    end
  end

endmodule

// File: rtl/capture_unit.sv
// Circular-buffer capture controller: pre-trigger fill, trigger arm, post-trigger count.
// Define CAPTURE_DECIMATE_EN to enable strobe decimation via capture_decim.
module capture_unit
  import capture_pkg::*;
#(
  parameter int ENTRIES = CAP_ENTRIES,
  parameter int ADDR_W  = CAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt_smpl,
  input  logic              run,
  input  logic              capture_done,
  input  logic              triggered,
  input  logic [3:0]        decimator,
  input  logic [ADDR_W-1:0] trig_pos,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              set_capture_done,
  output logic              armed
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int SUM_W = ADDR_W + 2;

  cap_state_t        state_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [ADDR_W-1:0] post_cnt_reg;
  logic [CNT_W-1:0]  smpl_cnt_reg;
  logic              armed_reg;
  logic              set_capture_done_reg;

  logic              start;
  logic              sampling;
  logic              keep;
  logic              store;
  logic [ADDR_W-1:0] waddr_inc;
  logic [CNT_W-1:0]  smpl_cnt_next;
  logic              arm_hit;
  logic              post_done;

  assign start    = (state_reg == IDLE) && run && !capture_done;
  assign sampling = (state_reg == CAPTURE) || (state_reg == POST);

`ifdef CAPTURE_DECIMATE_EN
  capture_decim u_decim (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .en        (sampling),
    .wrt_smpl  (wrt_smpl),
    .decimator (decimator),
    .keep      (keep)
  );
`else
  logic decimator_unused;
  assign decimator_unused = ^decimator;
  assign keep             = sampling && wrt_smpl;
`endif

  // Once the post-trigger count is reached no further sample may land in the buffer.
  always_comb begin
    store = 1'b0;
    case (state_reg)
      CAPTURE: store = keep;
      POST:    store = keep && (post_cnt_reg != trig_pos);
      default: store = 1'b0;
    endcase
  end

  assign waddr_inc     = (waddr_reg == ADDR_W'(ENTRIES - 1)) ? '0 : waddr_reg + ADDR_W'(1);
  assign smpl_cnt_next = (store && (smpl_cnt_reg != CNT_W'(ENTRIES)))
                         ? smpl_cnt_reg + CNT_W'(1) : smpl_cnt_reg;
  assign arm_hit       = (SUM_W'(smpl_cnt_next) + SUM_W'(trig_pos)) >= SUM_W'(ENTRIES);
  assign post_done     = (post_cnt_reg == trig_pos)
                         || (store && ((post_cnt_reg + ADDR_W'(1)) == trig_pos));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg            <= IDLE;
      waddr_reg            <= '0;
      post_cnt_reg         <= '0;
      smpl_cnt_reg         <= '0;
      armed_reg            <= 1'b0;
      set_capture_done_reg <= 1'b0;
    end else begin
      set_capture_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= CAPTURE;
            waddr_reg    <= '0;
            post_cnt_reg <= '0;
            smpl_cnt_reg <= '0;
            armed_reg    <= 1'b0;
          end
        end
        CAPTURE: begin
          if (store) begin
            waddr_reg    <= waddr_inc;
            smpl_cnt_reg <= smpl_cnt_next;
          end
          if (!run) begin
            state_reg <= IDLE;
            armed_reg <= 1'b0;
          end else begin
            if (arm_hit) begin
              armed_reg <= 1'b1;
            end
            if (triggered && armed_reg) begin
              state_reg    <= POST;
              post_cnt_reg <= '0;
            end
          end
        end
        POST: begin
          if (store) begin
            waddr_reg    <= waddr_inc;
            post_cnt_reg <= post_cnt_reg + ADDR_W'(1);
          end
          if (!run) begin
            state_reg <= IDLE;
            armed_reg <= 1'b0;
          end else if (post_done) begin
            state_reg            <= DONE;
            set_capture_done_reg <= 1'b1;
          end
        end
        DONE: begin
          // Give the config block the pulse cycle to raise capture_done before testing it.
          if (!capture_done && !set_capture_done_reg) begin
            state_reg <= IDLE;
            armed_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign we               = store;
  assign waddr            = waddr_reg;
  assign set_capture_done = set_capture_done_reg;
  assign armed            = armed_reg;

endmodule
